// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter/sequencer in front of the data-memory BRAM.
// Port 0 is the CPU load/store path and port 1 is the debug/loader path.
// Word accesses from both ports are serialised onto one memory command port.
// BRAM read latency is hidden behind a req/gnt/rvalid handshake, and read data
// goes back only to the port that asked for it.
//
// Build option: define ROUND_ROBIN_EN to alternate the winner on contention,
// based on a last-grant pointer. Without it, port 0 has fixed priority and
// no pointer logic is built.
//
// Timing, counting from the IDLE cycle that samples req as cycle 0:
//   gnt    : cycle 1 (ISSUE)
//   rvalid : cycle 2+RD_LAT (RESP)
//   a write occupies 2 cycles; a read occupies 3+RD_LAT cycles
module dmem_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic                clk,
  input  logic                rst,
  // port 0: CPU load/store
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [WIDTH-1:0]    p0_addr,
  input  logic [WIDTH-1:0]    p0_wdata,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [WIDTH-1:0]    p0_rdata,
  // port 1: debug / program loader
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [WIDTH-1:0]    p1_addr,
  input  logic [WIDTH-1:0]    p1_wdata,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [WIDTH-1:0]    p1_rdata,
  // memory command port
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                busy
);

  localparam int NP = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Requester bundles, indexed by port number
  // ---------------------------------------------------------------------------
  logic [NP-1:0]             req_v;
  logic [NP-1:0]             we_v;
  logic [NP-1:0][WIDTH-1:0]  addr_v;
  logic [NP-1:0][WIDTH-1:0]  wdata_v;

  assign req_v   = {p1_req, p0_req};
  assign we_v    = {p1_we, p0_we};
  assign addr_v  = {p1_addr, p0_addr};
  assign wdata_v = {p1_wdata, p0_wdata};

  // Byte-lane bits and bits above ADDR_W are intentionally ignored (word
  // access, addresses alias modulo 2^ADDR_W).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_addr, p1_addr};

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t                    state_q,     state_d;
  logic                      owner_q,     owner_d;     // port being served
  logic [2:0]                cnt_q,       cnt_d;       // read latency countdown
  logic [NP-1:0]             gnt_q,       gnt_d;
  logic [NP-1:0]             rvalid_q,    rvalid_d;
  logic [NP-1:0][WIDTH-1:0]  rdata_q,     rdata_d;
  logic                      mem_en_q,    mem_en_d;
  logic                      mem_we_q,    mem_we_d;
  logic [ADDR_W-3:0]         mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]          mem_wdata_q, mem_wdata_d;
  logic                      busy_q,      busy_d;

  // Winner of the current IDLE arbitration
  logic                      win_sel;

`ifdef ROUND_ROBIN_EN
  // Last-grant pointer: names the port that won most recently
  logic                      last_q, last_d;

  // Contention goes to the port not named by the pointer; a single request
  // wins regardless of the pointer
  always_comb begin
    win_sel = 1'b0;
    if (req_v[0] && req_v[1]) begin
      win_sel = ~last_q;
    end else begin
      win_sel = ~req_v[0];
    end
  end

  // The pointer follows every grant
  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (|req_v)) begin
      last_d = win_sel;
    end
  end

  // Pointer register; it starts out naming port 1, so port 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests
  always_comb begin
    win_sel = ~req_v[0];
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequencer: next state and next registered outputs
  // ---------------------------------------------------------------------------
  // Pulses default low and everything else holds, so each state only states
  // what it changes
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        // req is sampled only here; a late requester simply waits
        if (|req_v) begin
          owner_d          = win_sel;
          gnt_d[win_sel]   = 1'b1;
          mem_en_d         = 1'b1;
          mem_we_d         = we_v[win_sel];
          mem_addr_d       = addr_v[win_sel][ADDR_W-1:2];
          mem_wdata_d      = wdata_v[win_sel];
          state_d          = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The memory command lasts exactly this one cycle
        mem_we_d = 1'b0;
        if (mem_we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The BRAM output is valid in the last WAIT cycle; capture it straight
        // into the owner's rdata so it shows up together with rvalid
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d[owner_q]  = mem_rdata;
          rvalid_d[owner_q] = 1'b1;
          state_d           = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any in-flight access
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign p0_gnt    = gnt_q[0];
  assign p0_rvalid = rvalid_q[0];
  assign p0_rdata  = rdata_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p1_rvalid = rvalid_q[1];
  assign p1_rdata  = rdata_q[1];

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
